dma_timing_ctrl: RTL and testbench

DMA_TIMING_CTRL -- requirements
Module: dma_timing_ctrl

---
 rtl/dma_timing_ctrl.sv | 140 ++++++++++++++
 tb/tb_dma_timing_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_timing_ctrl.sv
// rtl/dma_timing_ctrl.sv - single-channel DMA transfer timing controller
module dma_timing_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             DREQ,
    input  logic             HLDA,
    input  logic             CS_N,
    input  logic             EOP_IN_N,
    input  logic [CNT_W-1:0] baseAddr,
    input  logic [CNT_W-1:0] baseCount,
    input  logic             load,
    input  logic [1:0]       xferType,
    input  logic             autoInit,
    input  logic             blockMode,
    input  logic             addrDec,
    input  logic             clrTc,
    output logic             HRQ,
    output logic             DACK,
    output logic             AEN,
    output logic             ADSTB,
    output logic             EOP_OUT_N,
    output logic             enIoRead,
    output logic             enIoWrite,
    output logic             enMemRead,
    output logic             enMemWrite,
    output logic             enAddrUp,
    output logic             enAddrLow,
    output logic             enRegAddr,
    output logic             enIoAddrBuf,
    output logic [CNT_W-1:0] curAddr,
    output logic             tc
);

    localparam logic [2:0] ST_SI = 3'd0;
    localparam logic [2:0] ST_S0 = 3'd1;
    localparam logic [2:0] ST_S1 = 3'd2;
    localparam logic [2:0] ST_S2 = 3'd3;
    localparam logic [2:0] ST_S3 = 3'd4;
    localparam logic [2:0] ST_S4 = 3'd5;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cur_count;
    logic             mask;
    logic             eop_latch;
    logic             in_xfer;
    logic             in_cmd;
    logic             count_zero;
    logic             terminate;
    logic             is_read;
    logic             is_write;

    assign in_xfer    = (state == ST_S1) || (state == ST_S2) || (state == ST_S3) || (state == ST_S4);
    assign in_cmd     = (state == ST_S2) || (state == ST_S3) || (state == ST_S4);
    assign count_zero = (cur_count == '0);
    // An EOP arriving during S4 itself still ends the service at this S4 exit.
    assign terminate  = (state == ST_S4) && (count_zero || eop_latch || !EOP_IN_N);
    assign is_read    = (xferType == 2'b10);
    assign is_write   = (xferType == 2'b01);

    // Next-state selection: request in idle, hold handshake, fixed S1..S4 cycle, then continue or stop.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SI: if (DREQ && CS_N && !mask) state_nxt = ST_S0;
            ST_S0: if (HLDA) state_nxt = ST_S1;
            ST_S1: state_nxt = ST_S2;
            ST_S2: state_nxt = ST_S3;
            ST_S3: state_nxt = ST_S4;
            ST_S4: begin
                if (terminate || !blockMode || !HLDA) state_nxt = ST_SI;
                else                                  state_nxt = ST_S1;
            end
            default: state_nxt = ST_SI;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_SI;
        else          state <= state_nxt;
    end

    // Address/count, channel mask, EOP latch and sticky terminal count.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            curAddr   <= '0;
            cur_count <= '0;
            mask      <= 1'b1;
            eop_latch <= 1'b0;
            tc        <= 1'b0;
        end else begin
            if (state == ST_SI) begin
                if (load) begin
                    curAddr   <= baseAddr;
                    cur_count <= baseCount;
                    mask      <= 1'b0;
                end
            end else if (state == ST_S4) begin
                if (terminate && autoInit) begin
                    curAddr   <= baseAddr;
                    cur_count <= baseCount;
                end else begin
                    curAddr   <= addrDec ? (curAddr - ONE) : (curAddr + ONE);
                    cur_count <= cur_count - ONE;
                end
                if (terminate && !autoInit) mask <= 1'b1;
            end

            if (terminate)                 eop_latch <= 1'b0;
            else if (in_xfer && !EOP_IN_N) eop_latch <= 1'b1;

            // A terminal count on the same edge as clrTc leaves tc set.
            if (terminate && count_zero) tc <= 1'b1;
            else if (clrTc)              tc <= 1'b0;
        end
    end

    // Moore decode of bus controls; gating with RESET_N drops everything the instant reset asserts.
    always_comb begin
        HRQ         = RESET_N && (state != ST_SI);
        DACK        = RESET_N && in_xfer;
        AEN         = RESET_N && in_xfer;
        ADSTB       = RESET_N && (state == ST_S1);
        enAddrUp    = RESET_N && in_xfer;
        enAddrLow   = RESET_N && in_xfer;
        enMemRead   = RESET_N && in_cmd && is_read;
        enIoWrite   = RESET_N && in_cmd && is_read;
        enIoRead    = RESET_N && in_cmd && is_write;
        enMemWrite  = RESET_N && in_cmd && is_write;
        enRegAddr   = RESET_N && (state == ST_SI) && !CS_N;
        enIoAddrBuf = RESET_N && (state == ST_SI) && !CS_N;
        EOP_OUT_N   = !(RESET_N && (state == ST_S4) && count_zero);
    end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// tb/tb_dma_timing_ctrl.sv - randomized transaction-level bench for dma_timing_ctrl
module tb_dma_timing_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        DREQ = 1'b0;
    logic        HLDA = 1'b0;
    logic        CS_N = 1'b1;
    logic        EOP_IN_N = 1'b1;
    logic [15:0] baseAddr = '0;
    logic [15:0] baseCount = '0;
    logic        load = 1'b0;
    logic [1:0]  xferType = 2'b00;
    logic        autoInit = 1'b0;
    logic        blockMode = 1'b0;
    logic        addrDec = 1'b0;
    logic        clrTc = 1'b0;
    logic        HRQ, DACK, AEN, ADSTB, EOP_OUT_N;
    logic        enIoRead, enIoWrite, enMemRead, enMemWrite;
    logic        enAddrUp, enAddrLow, enRegAddr, enIoAddrBuf;
    logic [15:0] curAddr;
    logic        tc;

    int n_checks = 0;
    int n_fail   = 0;

    dma_timing_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .CS_N(CS_N),
        .EOP_IN_N(EOP_IN_N), .baseAddr(baseAddr), .baseCount(baseCount), .load(load),
        .xferType(xferType), .autoInit(autoInit), .blockMode(blockMode), .addrDec(addrDec),
        .clrTc(clrTc), .HRQ(HRQ), .DACK(DACK), .AEN(AEN), .ADSTB(ADSTB),
        .EOP_OUT_N(EOP_OUT_N), .enIoRead(enIoRead), .enIoWrite(enIoWrite),
        .enMemRead(enMemRead), .enMemWrite(enMemWrite), .enAddrUp(enAddrUp),
        .enAddrLow(enAddrLow), .enRegAddr(enRegAddr), .enIoAddrBuf(enIoAddrBuf),
        .curAddr(curAddr), .tc(tc)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_adstb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLK);
            if (ADSTB) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 150 && !ok; i++) begin
            @(negedge CLK);
            if (!HRQ) ok = 1'b1;
        end
    endtask

    // One programmed service: expected results follow from the count/EOP rules with plain arithmetic.
    task automatic run_case(input logic [15:0] b_addr, input logic [15:0] b_cnt, input logic [1:0] xt,
                            input logic au, input logic bk, input logic dc,
                            input int eop_at, input int eop_ph);
        int          n_exp, xf, since, hrq_rises, dack_cyc, strb_cyc, bad_cyc, eop_idx;
        bit          tc_exp, done, hrq_prev, hrq_seen, rd, wr, ok;
        logic [15:0] addrs[$];
        logic [15:0] exp_addr, exp_cnt, step;

        n_exp = int'(b_cnt) + 1;
        if (eop_at >= 0 && eop_at < n_exp) n_exp = eop_at + 1;
        tc_exp = (n_exp == int'(b_cnt) + 1);
        rd = (xt == 2'b10);
        wr = (xt == 2'b01);

        @(negedge CLK);
        DREQ = 1'b0; baseAddr = b_addr; baseCount = b_cnt; xferType = xt;
        autoInit = au; blockMode = bk; addrDec = dc; load = 1'b1; clrTc = 1'b1;
        @(negedge CLK);
        load = 1'b0; clrTc = 1'b0;
        check("tc_clr", 32'(tc), 32'd0);
        DREQ = 1'b1; HLDA = 1'b1;

        xf = 0; since = 9; hrq_rises = 0; dack_cyc = 0; strb_cyc = 0; bad_cyc = 0;
        eop_idx = -1; done = 1'b0; hrq_prev = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge CLK);
            if (HRQ && !hrq_prev) hrq_rises++;
            hrq_prev = HRQ;
            if (ADSTB) begin
                addrs.push_back(curAddr);
                xf++;
                since = 0;
            end else begin
                since++;
            end
            if (DACK) dack_cyc++;
            if (!EOP_OUT_N) eop_idx = xf - 1;
            if (enMemRead || enMemWrite || enIoRead || enIoWrite) begin
                strb_cyc++;
                if (!DACK || ADSTB || ({enMemRead, enIoWrite, enIoRead, enMemWrite} != {rd, rd, wr, wr}))
                    bad_cyc++;
            end
            EOP_IN_N = !((xf - 1 == eop_at) && (since == eop_ph));
            if (ADSTB && xf == n_exp) DREQ = 1'b0;
            if (xf >= n_exp && !HRQ) done = 1'b1;
        end
        EOP_IN_N = 1'b1;
        DREQ = 1'b0;
        check("timeout", 32'(done), 32'd1);
        repeat (3) @(negedge CLK);
        check("idle_hrq", 32'(HRQ), 32'd0);
        check("xfers", 32'(xf), 32'(n_exp));
        for (int i = 0; i < n_exp && i < addrs.size(); i++) begin
            step = 16'(i);
            exp_addr = dc ? (b_addr - step) : (b_addr + step);
            check("addr", 32'(addrs[i]), 32'(exp_addr));
        end
        check("hrq_spans", 32'(hrq_rises), bk ? 32'd1 : 32'(n_exp));
        check("dack_cycles", 32'(dack_cyc), 32'(4 * n_exp));
        check("strobe_cycles", 32'(strb_cyc), (rd || wr) ? 32'(3 * n_exp) : 32'd0);
        check("strobe_bad", 32'(bad_cyc), 32'd0);
        check("eop_out_idx", 32'(eop_idx), tc_exp ? 32'(b_cnt) : 32'hFFFF_FFFF);
        check("tc", 32'(tc), 32'(tc_exp));
        step = 16'(n_exp);
        exp_addr = au ? b_addr : (dc ? (b_addr - step) : (b_addr + step));
        exp_cnt  = au ? b_cnt : (tc_exp ? 16'hFFFF : (b_cnt - step));
        check("cur_addr", 32'(curAddr), 32'(exp_addr));
        check("cur_count", 32'(dut.cur_count), 32'(exp_cnt));

        DREQ = 1'b1;
        hrq_seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (HRQ) hrq_seen = 1'b1;
        end
        check("mask", 32'(hrq_seen), 32'(au));
        DREQ = 1'b0;
        wait_idle(ok);
        check("idle_after_mask", 32'(ok), 32'd1);
    endtask

    initial begin
        bit ok, hrq_seen;

        // Reset state, with CS_N low to show the register-access enables are also held off.
        CS_N = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        check("rst_outs", 32'({HRQ, DACK, AEN, ADSTB, enIoRead, enIoWrite, enMemRead, enMemWrite,
                               enAddrUp, enAddrLow, enRegAddr, enIoAddrBuf, tc}), 32'd0);
        check("rst_eop_out", 32'(EOP_OUT_N), 32'd1);
        check("rst_addr", 32'(curAddr), 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1; CS_N = 1'b1; DREQ = 1'b1; HLDA = 1'b1;
        hrq_seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (HRQ) hrq_seen = 1'b1;
        end
        check("rst_masked", 32'(hrq_seen), 32'd0);
        DREQ = 1'b0;

        // Directed services.
        run_case(16'h1000, 16'h0002, 2'b10, 1'b0, 1'b0, 1'b0, -1, 0);
        @(negedge CLK); clrTc = 1'b1;
        @(negedge CLK); clrTc = 1'b0;
        check("clr_tc", 32'(tc), 32'd0);
        run_case(16'h2000, 16'h0001, 2'b01, 1'b0, 1'b1, 1'b0, -1, 0);
        run_case(16'h4000, 16'h0005, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1);
        run_case(16'h00FF, 16'h0000, 2'b10, 1'b1, 1'b0, 1'b1, -1, 0);
        run_case(16'hFFFF, 16'h0001, 2'b11, 1'b0, 1'b1, 1'b0, -1, 0);
        run_case(16'h0000, 16'h0002, 2'b00, 1'b0, 1'b0, 1'b1, -1, 0);

        // Randomized services.
        for (int n = 0; n < 16; n++) begin
            logic [15:0] ra, rc;
            int          ea, ep;
            ra = 16'($urandom);
            rc = 16'($urandom_range(0, 5));
            ea = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
            ep = int'($urandom_range(0, 3));
            run_case(ra, rc, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), ea, ep);
        end

        // Reset during S3 of a read.
        @(negedge CLK);
        baseAddr = 16'h3000; baseCount = 16'h0005; xferType = 2'b10; autoInit = 1'b0;
        blockMode = 1'b0; addrDec = 1'b0; load = 1'b1;
        @(negedge CLK); load = 1'b0; DREQ = 1'b1;
        wait_adstb(ok);
        check("rst_mid_s1", 32'(ok), 32'd1);
        repeat (2) @(negedge CLK);
        check("rst_mid_active", 32'({enMemRead, enIoWrite, HRQ}), 32'h7);
        #1 RESET_N = 1'b0;
        #1;
        check("rst_mid_drop", 32'({enMemRead, enIoWrite, HRQ, DACK}), 32'd0);
        @(negedge CLK); RESET_N = 1'b1;
        @(negedge CLK);
        check("rst_mid_addr", 32'(curAddr), 32'd0);
        check("rst_mid_idle", 32'({HRQ, DACK, AEN}), 32'd0);
        DREQ = 1'b0;

        // load mid-transfer ignored; CS_N low in idle blocks requests and opens the register path.
        @(negedge CLK);
        baseAddr = 16'h2222; baseCount = 16'h0003; load = 1'b1;
        @(negedge CLK); load = 1'b0; DREQ = 1'b1;
        wait_adstb(ok);
        check("ld_s1", 32'(ok), 32'd1);
        @(negedge CLK);
        baseAddr = 16'h5555; baseCount = 16'h0009; load = 1'b1; DREQ = 1'b0; CS_N = 1'b0;
        @(negedge CLK); load = 1'b0;
        wait_idle(ok);
        check("ld_idle", 32'(ok), 32'd1);
        check("ld_ignored_addr", 32'(curAddr), 32'h2223);
        check("ld_ignored_cnt", 32'(dut.cur_count), 32'h0002);
        check("cs_reg_en", 32'({enRegAddr, enIoAddrBuf}), 32'h3);
        DREQ = 1'b1;
        hrq_seen = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (HRQ) hrq_seen = 1'b1;
        end
        check("cs_blocks_req", 32'(hrq_seen), 32'd0);
        CS_N = 1'b1;
        hrq_seen = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (HRQ) hrq_seen = 1'b1;
        end
        check("cs_release_req", 32'(hrq_seen), 32'd1);
        DREQ = 1'b0;
        wait_idle(ok);
        check("final_idle", 32'(ok), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
